// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment and range check, request/ack bus master
// with timeout, byte-lane steering and load extension. Stalls while busy.
module mem_access_unit #(
  parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_vaddr
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_op;      // op[3]=store, op[2]=unsigned, op[1:0]=size
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [7:0]  r_cnt;
  logic        r_kill, r_exc;
  logic [4:0]  r_code;

  logic        w_legal, w_mis, w_in_dm, w_in_dev, w_fault, w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  always_comb begin
    case (op)
      6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
      6'b101000, 6'b101001, 6'b101011: w_legal = 1'b1;
      default:                          w_legal = 1'b0;
    endcase
  end

  // Device windows only accept word accesses; anything else there is a fault.
  assign w_mis    = ((op[1:0] == 2'b01) && addr[0]) ||
                    ((op[1:0] == 2'b11) && (addr[1:0] != 2'b00));
  assign w_in_dm  = (addr <= DM_LIMIT);
  assign w_in_dev = ((addr >= DEV0_BASE) && (addr <= DEV0_BASE + 32'd11)) ||
                    ((addr >= DEV1_BASE) && (addr <= DEV1_BASE + 32'd11));
  assign w_fault  = w_mis || !(w_in_dm || w_in_dev) ||
                    (w_in_dev && (op[1:0] != 2'b11));
  assign w_accept = (r_state == S_IDLE) && req_valid && w_legal && !flush;

  assign w_byte = 8'(bus_rdata >> {r_addr[1:0], 3'b000});
  assign w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (r_op[1:0])
      2'b00:   w_ext = r_op[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_op[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fault ? S_RESP : S_BUS;
      S_BUS:  if (bus_ack || (r_cnt == CNT_LAST)) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_kill  <= 1'b0;
      r_exc   <= 1'b0;
      r_code  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= op[3:0];
          r_addr  <= addr;
          r_wdata <= wdata;
          r_cnt   <= '0;
          r_kill  <= 1'b0;
          r_exc   <= w_fault;
          r_code  <= op[3] ? 5'd5 : 5'd4;
        end
        S_BUS: begin
          if (flush) r_kill <= 1'b1;
          // ack beats a coincident timeout
          if (bus_ack) begin
            r_rdata <= w_ext;
            r_exc   <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_exc   <= 1'b1;
            r_code  <= 5'd7;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        S_RESP: r_kill <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall      = !reset && (w_accept || (r_state == S_BUS));
    bus_req    = (r_state == S_BUS);
    bus_we     = bus_req && r_op[3];
    bus_addr   = bus_req ? {r_addr[31:2], 2'b00} : 32'h0;
    bus_be     = 4'h0;
    bus_wdata  = 32'h0;
    if (bus_req) begin
      case (r_op[1:0])
        2'b00:   begin bus_be = 4'b0001 << r_addr[1:0];          bus_wdata = {4{r_wdata[7:0]}};  end
        2'b01:   begin bus_be = r_addr[1] ? 4'b1100 : 4'b0011;   bus_wdata = {2{r_wdata[15:0]}}; end
        default: begin bus_be = 4'b1111;                         bus_wdata = r_wdata;            end
      endcase
      if (!r_op[3]) bus_wdata = 32'h0;
    end
    resp_valid = (r_state == S_RESP) && !r_kill && !flush;
    exc        = resp_valid && r_exc;
    exc_code   = exc ? r_code : 5'd0;
    bad_vaddr  = exc ? r_addr : 32'h0;
    rdata      = (resp_valid && !r_exc && !r_op[3]) ? r_rdata : 32'h0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors driven through a
// bus responder task with programmable wait states, flush and timeout.
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, flush = 1'b0, bus_ack = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic        stall, bus_req, bus_we, resp_valid, exc;
  logic [31:0] bus_addr, bus_wdata, rdata, bad_vaddr;
  logic [3:0]  bus_be;
  logic [4:0]  exc_code;

  int n_cmp = 0, n_err = 0;
  int n_stall, n_req;
  logic        got_resp, q_exc, q_we;
  logic [31:0] q_rdata, q_bad, q_bwd, q_baddr;
  logic [4:0]  q_code;
  logic [3:0]  q_be;

  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001,
                         LHU = 6'b100101, LW = 6'b100011, SB = 6'b101000,
                         SH = 6'b101001, SW = 6'b101011;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op), .addr(addr),
    .wdata(wdata), .flush(flush), .stall(stall), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .resp_valid(resp_valid), .rdata(rdata), .exc(exc), .exc_code(exc_code),
    .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; ack on BUS cycle index `waits` (-1 = never), flush on
  // BUS cycle index `flush_at` (-1 = never). Returns at the RESP cycle.
  task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                     input int waits, input logic [31:0] rd, input int flush_at);
    int  bidx;
    bit  done;
    @(posedge clk); #1;
    req_valid = 1'b1; op = o; addr = a; wdata = wd;
    #1;
    n_stall = stall ? 1 : 0; n_req = 0; got_resp = 0;
    q_rdata = '0; q_exc = 0; q_code = '0; q_bad = '0;
    q_be = '0; q_bwd = '0; q_we = 0; q_baddr = '0;
    bidx = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      bus_ack   = (waits >= 0) && (bidx == waits);
      bus_rdata = bus_ack ? rd : 32'h0;
      flush     = (bidx == flush_at);
      #1;
      if (bus_req) begin
        n_req++; bidx++;
        q_be = bus_be; q_bwd = bus_wdata; q_we = bus_we; q_baddr = bus_addr;
      end
      if (stall) n_stall++;
      if (resp_valid) begin
        got_resp = 1; q_rdata = rdata; q_exc = exc; q_code = exc_code; q_bad = bad_vaddr;
      end
      if (!stall && !bus_req) done = 1;
    end
    bus_ack = 1'b0; bus_rdata = '0; flush = 1'b0;
    if (!done) chk("run_bound", 32'd0, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_busreq", bus_req, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bad", bad_vaddr, 0);
    #20 reset = 1'b0;

    // lb sign-extend from lane 3, two wait states
    run(LB, 32'h13, 32'h0, 2, 32'h80FF_1234, -1);
    chk("lb_stall", n_stall, 4);
    chk("lb_req", n_req, 3);
    chk("lb_be", q_be, 4'b1000);
    chk("lb_we", q_we, 0);
    chk("lb_baddr", q_baddr, 32'h10);
    chk("lb_resp", got_resp, 1);
    chk("lb_rdata", q_rdata, 32'hFFFF_FF80);
    @(posedge clk); #2;
    chk("lb_pulse1", resp_valid, 0);

    run(LHU, 32'h102, 32'h0, 0, 32'hBEEF_0001, -1);
    chk("lhu_rdata", q_rdata, 32'h0000_BEEF);
    chk("lhu_exc", q_exc, 0);
    chk("lhu_be", q_be, 4'b1100);

    run(SH, 32'h102, 32'h0000_ABCD, 0, 32'h0, -1);
    chk("sh_be", q_be, 4'b1100);
    chk("sh_wdata", q_bwd, 32'hABCD_ABCD);
    chk("sh_we", q_we, 1);
    chk("sh_rdata", q_rdata, 0);

    run(LH, 32'h2, 32'h0, 1, 32'h8001_0000, -1);
    chk("lh_rdata", q_rdata, 32'hFFFF_8001);
    run(LBU, 32'h1, 32'h0, 0, 32'h0000_F200, -1);
    chk("lbu_rdata", q_rdata, 32'h0000_00F2);
    run(SB, 32'h1, 32'h1234_56AB, 0, 32'h0, -1);
    chk("sb_be", q_be, 4'b0010);
    chk("sb_wdata", q_bwd, 32'hABAB_ABAB);

    // faults never touch the bus
    run(LW, 32'h6, 32'h0, 0, 32'h0, -1);
    chk("lw6_req", n_req, 0);
    chk("lw6_stall", n_stall, 1);
    chk("lw6_exc", q_exc, 1);
    chk("lw6_code", q_code, 4);
    chk("lw6_bad", q_bad, 32'h6);
    run(SW, 32'h3000, 32'h0, 0, 32'h0, -1);
    chk("sw3000_code", q_code, 5);
    chk("sw3000_req", n_req, 0);
    run(SB, 32'h7F04, 32'h0, 0, 32'h0, -1);
    chk("sbdev_code", q_code, 5);
    chk("sbdev_exc", q_exc, 1);
    run(LW, 32'h7F08, 32'h0, 1, 32'h1234_5678, -1);
    chk("lwdev_exc", q_exc, 0);
    chk("lwdev_req", n_req, 2);
    chk("lwdev_rdata", q_rdata, 32'h1234_5678);

    // timeout
    run(LW, 32'h20, 32'h0, -1, 32'h0, -1);
    chk("to_req", n_req, 16);
    chk("to_exc", q_exc, 1);
    chk("to_code", q_code, 7);
    chk("to_bad", q_bad, 32'h20);

    // ack on the exact timeout cycle wins
    run(LW, 32'h24, 32'h0, 15, 32'hCAFE_F00D, -1);
    chk("acklast_req", n_req, 16);
    chk("acklast_exc", q_exc, 0);
    chk("acklast_rdata", q_rdata, 32'hCAFE_F00D);

    // flush during BUS: write completes, response suppressed
    run(SW, 32'h40, 32'hDEAD_BEEF, 3, 32'h0, 1);
    chk("fl_req", n_req, 4);
    chk("fl_be", q_be, 4'b1111);
    chk("fl_wdata", q_bwd, 32'hDEAD_BEEF);
    chk("fl_resp", got_resp, 0);
    run(LW, 32'h44, 32'h0, 0, 32'h0000_0055, -1);
    chk("fl_next_resp", got_resp, 1);
    chk("fl_next_rdata", q_rdata, 32'h55);

    // illegal opcode is ignored
    @(posedge clk); #1;
    req_valid = 1'b1; op = 6'b100010; addr = 32'h8;
    #1 chk("ill_stall", stall, 0);
    @(posedge clk); #1 req_valid = 1'b0;
    #1 chk("ill_req", bus_req, 0);

    // reset mid-BUS
    @(posedge clk); #1;
    req_valid = 1'b1; op = LW; addr = 32'h80;
    @(posedge clk); #1 req_valid = 1'b0;
    #1 chk("mr_busreq_pre", bus_req, 1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("mr_busreq", bus_req, 0);
    chk("mr_stall", stall, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("mr_noresp", {bus_req, resp_valid}, 2'b00);
    end
    run(LW, 32'h84, 32'h0, 0, 32'h0BAD_F00D, -1);
    chk("mr_after_rdata", q_rdata, 32'h0BAD_F00D);
    chk("mr_after_exc", q_exc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
